hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised forwarding and interlock unit for the in-order core.
- Replaces hand-written exec/mem bypass and load-use block logic with a DEPTH-stage in-flight write tracker.
- Sits between decode (issue slot) and the execute operand muxes.
- Supplies forwarded operand values, per-source bypass selects and a stall request.
- Handles variable result latency, NUM_SRC sources, external hold and issue-slot flush.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, architectural register count; REG_W = clog2(NREGS).
- DEPTH, 3, tracked stages after issue (stage 0 = execute output, DEPTH-1 = last stage before GPR commit).
- NUM_SRC, 2, source operands per instruction.
- LAT_W, clog2(DEPTH+1), width of latency and select fields.

Ports:
- _clk  in  1  core clock.
- _reset_n  in  1  asynchronous active-low reset.
- _iss_valid  in  1  issue slot holds a real instruction.
- _iss_rs  in  NUM_SRC*REG_W  source register indices.
- _iss_rs_used  in  NUM_SRC  source actually read (e.g. rs2 unused for imm ops).
- _iss_rd  in  REG_W  destination register.
- _iss_wb_we  in  1  instruction writes rd.
- _iss_lat  in  LAT_W  first stage index where result is valid: ALU=0, load=MEM stage, DEPTH=regfile only.
- _flush  in  1  kill issue-slot instruction (misprediction).
- _hold  in  1  freeze the whole tracked pipeline (memory wait).
- _stage_data  in  DEPTH*XLEN  result value currently held in each stage.
- _gpr_rdata  in  NUM_SRC*XLEN  register file read data per source.
- op_  out  NUM_SRC*XLEN  resolved operand values.
- byp_sel_  out  NUM_SRC*LAT_W  0 = GPR/zero, k+1 = forwarded from stage k.
- stall_  out  1  issue instruction must not advance this cycle.

Behaviour:
- State: DEPTH entries {valid, rd, lat}. Entries with we=0 or rd=0 are stored invalid.
- Async reset: all entries invalid. With no valid entries, stall_=0, byp_sel_=0, op_=_gpr_rdata.
- Per source s, a match is stage k with entry valid, rd==rs[s], rs[s]!=0 and used[s].
- Youngest matching stage (lowest k) wins. Older matches are ignored even if they are ready.
- Winner ready (k >= lat): byp_sel_=k+1 and op_=_stage_data[k].
- Winner not ready: source is blocked; op_ and byp_sel_ are don't-care.
- No match: byp_sel_=0; op_=0 if rs==0, else _gpr_rdata.
- stall_ = _iss_valid & !_flush & (any source blocked). Fully combinational from inputs and state.
- Clock edge, _hold=1: all entries keep their values; the issue instruction is not captured.
- Clock edge, _hold=0: entry k moves to k+1. Entry DEPTH-1 retires; its result is visible in _gpr_rdata from the next cycle.
- Stage 0 load on advance: bubble if stall_ | _flush | !_iss_valid; otherwise {1, _iss_rd, _iss_lat}.
- Simultaneous _flush and stall_: flush wins; stall_=0 and a bubble is inserted.
- Simultaneous _hold and stall_: hold dominates state; stall_ is still reported.
- _iss_lat > DEPTH: treated as DEPTH; the consumer stalls until retire.
- Reset asserted mid-operation: in-flight entries are dropped immediately. The upstream core must also restart.

Optional Feature:
- Macro HAZARD_SCOREBOARD_STATS_EN.
- Defined, adds outputs stall_cnt_ (32) and fwd_cnt_ (32), both reset to 0.
- stall_cnt_ increments on every edge with stall_=1 and _hold=0.
- fwd_cnt_ increments per edge by the number of sources with byp_sel_!=0 in an accepted issue.
- Both counters saturate at all-ones.
- Undefined: ports absent, no counter logic.

Decomposition:
- Shared header core/hazard_defs.v holds:
  - `define HZ_SEL_GPR 0
  - latency constants: HZ_LAT_ALU=0, HZ_LAT_MEM=1, HZ_LAT_PCNEXT=0
  - the entry field layout
- One sub-module, hazard_src_resolve: a per-source priority match and mux, instantiated NUM_SRC times via generate.

Test Plan:
- ALU chain (defaults): x5=x0+7 then x6=x5+1 -> second issue shows byp_sel_[0]=1, op_[0]=7, no stall.
- Load-use: lw x5 (lat=1) then add x6,x5,x5 -> stall_=1 for exactly 1 cycle, then byp_sel_=2 for both sources, op_=_stage_data[1].
- Priority and x0: x5 in stages 0 and 2 -> sel=1. Any producer with rd=x0 -> op_=0, sel=0, no stall.
- Distance DEPTH: producer retires, consumer issues DEPTH+1 cycles later -> sel=0, op_=_gpr_rdata.
- Hold/flush: _hold=1 for 3 cycles during load-use -> entries frozen, stall_ stays 1. _flush with blocked consumer -> stall_=0, bubble enters stage 0.
- Reset mid-flight with 3 valid entries, plus stats build -> all sels 0 next cycle; stall_cnt_ counts exactly the single load-use stall.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and entry layout for the hazard scoreboard.
// Entry layout, MSB first: {valid, rd, lat}.
package hazard_scoreboard_pkg;

    localparam int HZ_SEL_GPR    = 0;
    localparam int HZ_LAT_ALU    = 0;
    localparam int HZ_LAT_MEM    = 1;
    localparam int HZ_LAT_PCNEXT = 0;
    localparam int HZ_CNT_W      = 32;

    function automatic int hz_ent_w(input int reg_w, input int lat_w);
        return 1 + reg_w + lat_w;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue-slot / operand bundle between decode and the hazard scoreboard.
// Stats counters exist only with HAZARD_SCOREBOARD_STATS_EN.
interface hazard_scoreboard_if #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2
);
    localparam int REG_W = $clog2(NREGS);
    localparam int LAT_W = $clog2(DEPTH + 1);

    logic                     _iss_valid;
    logic [NUM_SRC*REG_W-1:0] _iss_rs;
    logic [NUM_SRC-1:0]       _iss_rs_used;
    logic [REG_W-1:0]         _iss_rd;
    logic                     _iss_wb_we;
    logic [LAT_W-1:0]         _iss_lat;
    logic                     _flush;
    logic                     _hold;
    logic [DEPTH*XLEN-1:0]    _stage_data;
    logic [NUM_SRC*XLEN-1:0]  _gpr_rdata;
    logic [NUM_SRC*XLEN-1:0]  op_;
    logic [NUM_SRC*LAT_W-1:0] byp_sel_;
    logic                     stall_;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0]              stall_cnt_;
    logic [31:0]              fwd_cnt_;

    modport master (
        output _iss_valid, _iss_rs, _iss_rs_used, _iss_rd, _iss_wb_we,
        output _iss_lat, _flush, _hold, _stage_data, _gpr_rdata,
        input  op_, byp_sel_, stall_, stall_cnt_, fwd_cnt_
    );
    modport slave (
        input  _iss_valid, _iss_rs, _iss_rs_used, _iss_rd, _iss_wb_we,
        input  _iss_lat, _flush, _hold, _stage_data, _gpr_rdata,
        output op_, byp_sel_, stall_, stall_cnt_, fwd_cnt_
    );
`else
    modport master (
        output _iss_valid, _iss_rs, _iss_rs_used, _iss_rd, _iss_wb_we,
        output _iss_lat, _flush, _hold, _stage_data, _gpr_rdata,
        input  op_, byp_sel_, stall_
    );
    modport slave (
        input  _iss_valid, _iss_rs, _iss_rs_used, _iss_rd, _iss_wb_we,
        input  _iss_lat, _flush, _hold, _stage_data, _gpr_rdata,
        output op_, byp_sel_, stall_
    );
`endif
endinterface

// File: rtl/hazard_src_resolve.sv
// Per-source priority match against in-flight writes and operand mux.
module hazard_src_resolve
    import hazard_scoreboard_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 3,
    parameter int REG_W = 5,
    parameter int LAT_W = 2
) (
    input  logic [DEPTH-1:0]       ent_v,
    input  logic [DEPTH*REG_W-1:0] ent_rd,
    input  logic [DEPTH*LAT_W-1:0] ent_lat,
    input  logic [DEPTH*XLEN-1:0]  stage_data,
    input  logic [REG_W-1:0]       rs,
    input  logic                   used,
    input  logic [XLEN-1:0]        gpr,
    output logic [XLEN-1:0]        op,
    output logic [LAT_W-1:0]       sel,
    output logic                   blocked
);

    logic             hit;
    logic             rdy;
    logic [LAT_W-1:0] hsel;
    logic [XLEN-1:0]  hdat;

    // Scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        hit  = 1'b0;
        rdy  = 1'b0;
        hsel = '0;
        hdat = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_v[k] && ent_rd[k*REG_W +: REG_W] == rs &&
                rs != '0 && used) begin
                hit  = 1'b1;
                rdy  = LAT_W'(k) >= ent_lat[k*LAT_W +: LAT_W];
                hsel = LAT_W'(k + 1);
                hdat = stage_data[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        op      = (rs == '0) ? '0 : gpr;
        sel     = LAT_W'(HZ_SEL_GPR);
        blocked = 1'b0;
        if (hit) begin
            if (rdy) begin
                op  = hdat;
                sel = hsel;
            end else begin
                blocked = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// DEPTH-stage in-flight write tracker: forwarding selects and load-use stall.
// Optional counters: define HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2
) (
    input logic                _clk,
    input logic                _reset_n,
    hazard_scoreboard_if.slave bus
);

    localparam int REG_W = $clog2(NREGS);
    localparam int LAT_W = $clog2(DEPTH + 1);
    localparam int EW    = hz_ent_w(REG_W, LAT_W);

    logic [EW-1:0]            ent_q [DEPTH];
    logic [DEPTH-1:0]         ent_v;
    logic [DEPTH*REG_W-1:0]   ent_rd;
    logic [DEPTH*LAT_W-1:0]   ent_lat;
    logic [NUM_SRC-1:0]       blocked;
    logic [NUM_SRC*XLEN-1:0]  op_w;
    logic [NUM_SRC*LAT_W-1:0] sel_w;
    logic                     stall;
    logic                     accept;
    logic [LAT_W-1:0]         lat_in;
    logic [EW-1:0]            new_ent;

    for (genvar k = 0; k < DEPTH; k++) begin : g_unpack
        assign ent_v[k]                  = ent_q[k][EW-1];
        assign ent_rd[k*REG_W +: REG_W]  = ent_q[k][EW-2 -: REG_W];
        assign ent_lat[k*LAT_W +: LAT_W] = ent_q[k][LAT_W-1:0];
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        hazard_src_resolve #(
            .XLEN (XLEN),
            .DEPTH(DEPTH),
            .REG_W(REG_W),
            .LAT_W(LAT_W)
        ) u_src (
            .ent_v     (ent_v),
            .ent_rd    (ent_rd),
            .ent_lat   (ent_lat),
            .stage_data(bus._stage_data),
            .rs        (bus._iss_rs[s*REG_W +: REG_W]),
            .used      (bus._iss_rs_used[s]),
            .gpr       (bus._gpr_rdata[s*XLEN +: XLEN]),
            .op        (op_w[s*XLEN +: XLEN]),
            .sel       (sel_w[s*LAT_W +: LAT_W]),
            .blocked   (blocked[s])
        );
    end

    assign stall        = bus._iss_valid & ~bus._flush & (|blocked);
    assign accept       = bus._iss_valid & ~bus._flush & ~stall;
    assign bus.stall_   = stall;
    assign bus.op_      = op_w;
    assign bus.byp_sel_ = sel_w;

    // Latencies past the last stage only resolve through the regfile.
    assign lat_in  = (bus._iss_lat > LAT_W'(DEPTH)) ? LAT_W'(DEPTH)
                                                   : bus._iss_lat;
    assign new_ent = {accept & bus._iss_wb_we & (bus._iss_rd != '0),
                      bus._iss_rd, lat_in};

    always_ff @(posedge _clk or negedge _reset_n) begin
        if (!_reset_n) begin
            for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
        end else if (!bus._hold) begin
            ent_q[0] <= new_ent;
            for (int k = 1; k < DEPTH; k++) ent_q[k] <= ent_q[k-1];
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    localparam int CW = $clog2(NUM_SRC + 1);

    logic [CW-1:0]       fwd_n;
    logic [HZ_CNT_W:0]   fwd_sum;
    logic [HZ_CNT_W-1:0] stall_q;
    logic [HZ_CNT_W-1:0] fwd_q;

    always_comb begin
        fwd_n = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (sel_w[s*LAT_W +: LAT_W] != '0) fwd_n = fwd_n + 1'b1;
        end
    end

    assign fwd_sum = {1'b0, fwd_q} + (HZ_CNT_W+1)'(fwd_n);

    always_ff @(posedge _clk or negedge _reset_n) begin
        if (!_reset_n) begin
            stall_q <= '0;
            fwd_q   <= '0;
        end else if (!bus._hold) begin
            if (stall && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (accept) fwd_q <= fwd_sum[HZ_CNT_W] ? '1 : fwd_sum[HZ_CNT_W-1:0];
        end
    end

    assign bus.stall_cnt_ = stall_q;
    assign bus.fwd_cnt_   = fwd_q;
`endif

endmodule
